// File: rtl/usb_traffic_gen_chk.sv
// usb_traffic_gen_chk: pattern traffic generator and loopback checker for the ftdi_245fifo user ports.
module usb_traffic_gen_chk #(
    parameter int          DSIZE     = 16,
    parameter int          CNT_W     = 32,
    parameter int          ERR_W     = 16,
    parameter logic [31:0] LFSR_SEED = 32'hACE1_2468
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [1:0]       i_mode,
    input  logic [DSIZE-1:0] i_const_val,
    input  logic [CNT_W-1:0] i_pkt_len,
    output logic             o_tx_req,
    input  logic             i_tx_gnt,
    output logic [DSIZE-1:0] o_tx_data,
    output logic             o_rx_req,
    input  logic             i_rx_gnt,
    input  logic [DSIZE-1:0] i_rx_data,
    output logic             o_busy,
    output logic             o_done,
    output logic [CNT_W-1:0] o_tx_cnt,
    output logic [CNT_W-1:0] o_rx_cnt,
    output logic [ERR_W-1:0] o_err_cnt,
    output logic [CNT_W-1:0] o_err_first_idx,
    output logic [DSIZE-1:0] o_err_first_got,
    output logic [DSIZE-1:0] o_last_rx
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t r_state, w_next;
    logic [1:0]       r_mode;
    logic [CNT_W-1:0] r_len, r_tx_cnt, r_rx_cnt, r_err_idx;
    logic [31:0]      r_tx_gen, r_rx_gen;
    logic [ERR_W-1:0] r_err_cnt;
    logic [DSIZE-1:0] r_err_got, r_last_rx;
    logic             r_done, w_go, w_fin, w_tx_fire, w_rx_fire;

    function automatic logic [31:0] f_seed(input logic [1:0] m, input logic [DSIZE-1:0] c);
        return m == 2'd0 ? 32'd0 : m == 2'd1 ? LFSR_SEED : m == 2'd2 ? 32'd1 : 32'(c);
    endfunction

    // generator state is 32 bits so the LFSR keeps its full register; the word is the low DSIZE bits
    function automatic logic [31:0] f_adv(input logic [1:0] m, input logic [31:0] s);
        logic [DSIZE-1:0] w;
        w = s[DSIZE-1:0];
        return m == 2'd0 ? 32'(w + DSIZE'(1)) :
               m == 2'd1 ? ({1'b0, s[31:1]} ^ (s[0] ? 32'h8020_0003 : 32'd0)) :
               m == 2'd2 ? 32'({w[DSIZE-2:0], w[DSIZE-1]}) : s;
    endfunction

    assign w_go      = i_start && !i_abort && r_state != RUN;
    assign w_fin     = r_state == RUN && r_len != '0 && r_tx_cnt == r_len && r_rx_cnt == r_len;
    assign w_tx_fire = o_tx_req && i_tx_gnt;
    assign w_rx_fire = o_rx_req && i_rx_gnt;

    always_comb begin
        w_next = r_state;
        if (i_abort) w_next = IDLE;
        else if (w_go) w_next = RUN;
        else if (w_fin) w_next = DONE;
        o_busy   = r_state == RUN;
        o_tx_req = o_busy && (r_len == '0 || r_tx_cnt < r_len);
        o_rx_req = o_busy && (r_len == '0 || r_rx_cnt < r_len);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= IDLE;
            r_mode    <= '0;
            r_len     <= '0;
            r_tx_gen  <= '0;
            r_rx_gen  <= '0;
            r_tx_cnt  <= '0;
            r_rx_cnt  <= '0;
            r_err_cnt <= '0;
            r_err_idx <= '0;
            r_err_got <= '0;
            r_last_rx <= '0;
            r_done    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= !(i_abort || w_go) && (r_done || w_fin);
            if (w_go) begin
                r_mode    <= i_mode;
                r_len     <= i_pkt_len;
                r_tx_gen  <= f_seed(i_mode, i_const_val);
                r_rx_gen  <= f_seed(i_mode, i_const_val);
                r_tx_cnt  <= '0;
                r_rx_cnt  <= '0;
                r_err_cnt <= '0;
                r_err_idx <= '0;
                r_err_got <= '0;
                r_last_rx <= '0;
            end else begin
                if (w_tx_fire) begin
                    r_tx_gen <= f_adv(r_mode, r_tx_gen);
                    r_tx_cnt <= r_tx_cnt + CNT_W'(1);
                end
                if (w_rx_fire) begin
                    r_last_rx <= i_rx_data;
                    r_rx_cnt  <= r_rx_cnt + CNT_W'(1);
                    r_rx_gen  <= f_adv(r_mode, r_rx_gen);
                    if (i_rx_data != r_rx_gen[DSIZE-1:0]) begin
                        if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + ERR_W'(1);
                        if (r_err_cnt == '0) begin
                            r_err_idx <= r_rx_cnt;
                            r_err_got <= i_rx_data;
                        end
                    end
                end
            end
        end
    end

    assign o_done          = r_done;
    assign o_tx_data       = r_tx_gen[DSIZE-1:0];
    assign o_tx_cnt        = r_tx_cnt;
    assign o_rx_cnt        = r_rx_cnt;
    assign o_err_cnt       = r_err_cnt;
    assign o_err_first_idx = r_err_idx;
    assign o_err_first_got = r_err_got;
    assign o_last_rx       = r_last_rx;
endmodule

// File: tb/tb_usb_traffic_gen_chk.sv
// tb_usb_traffic_gen_chk: randomized loopback bench; a 16-bit DUT and an 8-bit DUT with a 4-bit error counter.
module tb_usb_traffic_gen_chk;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start_a, start_b, abort, tx_gnt, rx_gnt, sel;
    logic [1:0]  mode;
    logic [31:0] cval, len, rx_data;
    logic        a_tx_req, a_rx_req, a_busy, a_done, b_tx_req, b_rx_req, b_busy, b_done;
    logic [15:0] a_tx_data, a_err_cnt, a_err_got, a_last_rx;
    logic [31:0] a_tx_cnt, a_rx_cnt, a_err_idx, b_tx_cnt, b_rx_cnt, b_err_idx;
    logic [7:0]  b_tx_data, b_err_got, b_last_rx;
    logic [3:0]  b_err_cnt;
    int pass_n = 0, tot_n = 0;

    usb_traffic_gen_chk #(.DSIZE(16)) u_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start_a), .i_abort(abort), .i_mode(mode),
        .i_const_val(cval[15:0]), .i_pkt_len(len), .o_tx_req(a_tx_req), .i_tx_gnt(tx_gnt),
        .o_tx_data(a_tx_data), .o_rx_req(a_rx_req), .i_rx_gnt(rx_gnt), .i_rx_data(rx_data[15:0]),
        .o_busy(a_busy), .o_done(a_done), .o_tx_cnt(a_tx_cnt), .o_rx_cnt(a_rx_cnt),
        .o_err_cnt(a_err_cnt), .o_err_first_idx(a_err_idx), .o_err_first_got(a_err_got),
        .o_last_rx(a_last_rx));

    usb_traffic_gen_chk #(.DSIZE(8), .ERR_W(4)) u_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start_b), .i_abort(abort), .i_mode(mode),
        .i_const_val(cval[7:0]), .i_pkt_len(len), .o_tx_req(b_tx_req), .i_tx_gnt(tx_gnt),
        .o_tx_data(b_tx_data), .o_rx_req(b_rx_req), .i_rx_gnt(rx_gnt), .i_rx_data(rx_data[7:0]),
        .o_busy(b_busy), .o_done(b_done), .o_tx_cnt(b_tx_cnt), .o_rx_cnt(b_rx_cnt),
        .o_err_cnt(b_err_cnt), .o_err_first_idx(b_err_idx), .o_err_first_got(b_err_got),
        .o_last_rx(b_last_rx));

    // observed view of whichever DUT is selected
    logic        tx_req, rx_req, busy, done;
    logic [31:0] tx_data, tx_cnt, rx_cnt, err_cnt, err_idx, err_got, last_rx;
    assign tx_req  = sel ? b_tx_req : a_tx_req;
    assign rx_req  = sel ? b_rx_req : a_rx_req;
    assign busy    = sel ? b_busy : a_busy;
    assign done    = sel ? b_done : a_done;
    assign tx_data = sel ? 32'(b_tx_data) : 32'(a_tx_data);
    assign tx_cnt  = sel ? b_tx_cnt : a_tx_cnt;
    assign rx_cnt  = sel ? b_rx_cnt : a_rx_cnt;
    assign err_cnt = sel ? 32'(b_err_cnt) : 32'(a_err_cnt);
    assign err_idx = sel ? b_err_idx : a_err_idx;
    assign err_got = sel ? 32'(b_err_got) : 32'(a_err_got);
    assign last_rx = sel ? 32'(b_last_rx) : 32'(a_last_rx);

    // expected i-th word of a run, straight from the pattern definitions
    function automatic logic [31:0] nth_word(input logic [1:0] m, input logic [31:0] c, input int i, input int d);
        logic [31:0] mask, s;
        mask = (32'd1 << d) - 32'd1;
        if (m == 2'd0) return 32'(i) & mask;
        if (m == 2'd2) return 32'd1 << (i % d);
        if (m == 2'd3) return c & mask;
        s = 32'hACE1_2468;
        for (int k = 0; k < i; k++) s = (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'd0);
        return s & mask;
    endfunction

    task automatic run(input bit s, input logic [1:0] m, input logic [31:0] c, input int n,
                       input int txp, input int rxp, input int cidx, input logic [31:0] cmask,
                       input bit force_rx, input int stop_after,
                       output int tx_bad, output int req_bad, output int txi, output int rxi,
                       output logic [31:0] last);
        logic [31:0] q[$];
        int qt[$];
        int cyc, d;
        d = s ? 8 : 16;
        tx_bad = 0; req_bad = 0; txi = 0; rxi = 0; cyc = 0; last = '0;
        @(negedge clk);
        sel = s; mode = m; cval = c; len = 32'(n); tx_gnt = 0; rx_gnt = 0;
        if (s) start_b = 1; else start_a = 1;
        @(negedge clk);
        start_a = 0; start_b = 0;
        while (busy === 1'b1 && cyc < 20000) begin
            if (stop_after >= 0 && txi >= stop_after) begin
                abort = 1; tx_gnt = 0; rx_gnt = 0;
                @(negedge clk);
                abort = 0;
                break;
            end
            if (tx_req !== (n == 0 || txi < n)) req_bad++;
            if (rx_req !== (n == 0 || rxi < n)) req_bad++;
            tx_gnt = $urandom_range(99) < txp;
            if (tx_req && tx_gnt) begin
                if (tx_data !== nth_word(m, c, txi, d)) tx_bad++;
                q.push_back(txi == cidx ? tx_data ^ cmask : tx_data);
                qt.push_back(cyc + 2);
                txi++;
            end
            rx_gnt = 0;
            rx_data = $urandom;
            if (!rx_req) rx_gnt = 1'($urandom_range(1));
            else if (q.size() > 0 && qt[0] <= cyc && $urandom_range(99) < rxp) begin
                rx_gnt = 1;
                rx_data = q.pop_front();
                void'(qt.pop_front());
                if (force_rx) rx_data = 32'h55;
                last = rx_data;
                rxi++;
            end
            cyc++;
            @(negedge clk);
        end
        tx_gnt = 0; rx_gnt = 0;
    endtask

    task automatic test_reset();
        rst_n = 0; sel = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        tot_n++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL reset_state: busy=%0b done=%0b want 0 0", busy, done); else pass_n++;
        tot_n++; if (tx_cnt !== 0 || rx_cnt !== 0 || err_cnt !== 0) $display("FAIL reset_cnt: tx=%0d rx=%0d err=%0d want 0", tx_cnt, rx_cnt, err_cnt); else pass_n++;
        tot_n++; if (tx_req !== 1'b0 || rx_req !== 1'b0 || tx_data !== 0 || last_rx !== 0) $display("FAIL reset_out: txreq=%0b rxreq=%0b txd=%0h last=%0h want 0", tx_req, rx_req, tx_data, last_rx); else pass_n++;
    endtask

    task automatic test_incr();
        int tb, rb, ti, ri; logic [31:0] l;
        run(0, 2'd0, 0, 5, 100, 100, -1, 0, 0, -1, tb, rb, ti, ri, l);
        tot_n++; if (tb !== 0 || rb !== 0) $display("FAIL incr_stream: tx_bad=%0d req_bad=%0d want 0", tb, rb); else pass_n++;
        tot_n++; if (tx_cnt !== 5 || rx_cnt !== 5) $display("FAIL incr_cnt: tx=%0d rx=%0d want 5", tx_cnt, rx_cnt); else pass_n++;
        tot_n++; if (err_cnt !== 0 || done !== 1'b1 || busy !== 1'b0) $display("FAIL incr_end: err=%0d done=%0b busy=%0b want 0 1 0", err_cnt, done, busy); else pass_n++;
        tot_n++; if (last_rx !== 32'd4) $display("FAIL incr_last: got %0h want 4", last_rx); else pass_n++;
    endtask

    task automatic test_rx_ignored();
        @(negedge clk);
        rx_gnt = 1; rx_data = 32'hDEAD;
        @(negedge clk);
        rx_gnt = 0;
        tot_n++; if (rx_cnt !== 5 || last_rx !== 32'd4) $display("FAIL rx_ignored: rx=%0d last=%0h want 5 4", rx_cnt, last_rx); else pass_n++;
    endtask

    task automatic test_lfsr();
        int tb, rb, ti, ri; logic [31:0] l;
        run(0, 2'd1, 0, 1000, 60, 60, -1, 0, 0, -1, tb, rb, ti, ri, l);
        tot_n++; if (tb !== 0) $display("FAIL lfsr_stream: bad words=%0d want 0", tb); else pass_n++;
        tot_n++; if (rb !== 0) $display("FAIL lfsr_req: bad req cycles=%0d want 0", rb); else pass_n++;
        tot_n++; if (err_cnt !== 0 || done !== 1'b1 || rx_cnt !== 1000) $display("FAIL lfsr_end: err=%0d done=%0b rx=%0d want 0 1 1000", err_cnt, done, rx_cnt); else pass_n++;
    endtask

    task automatic test_error();
        int tb, rb, ti, ri; logic [31:0] l;
        run(0, 2'd0, 0, 8, 100, 70, 3, 32'h0100, 0, -1, tb, rb, ti, ri, l);
        tot_n++; if (err_cnt !== 1) $display("FAIL err_cnt: got %0d want 1", err_cnt); else pass_n++;
        tot_n++; if (err_idx !== 3 || err_got !== 32'h0103) $display("FAIL err_first: idx=%0d got=%0h want 3 103", err_idx, err_got); else pass_n++;
        tot_n++; if (rx_cnt !== 8 || done !== 1'b1) $display("FAIL err_end: rx=%0d done=%0b want 8 1", rx_cnt, done); else pass_n++;
    endtask

    task automatic test_walk();
        int tb, rb, ti, ri; logic [31:0] l;
        run(1, 2'd2, 0, 10, 100, 100, -1, 0, 0, -1, tb, rb, ti, ri, l);
        tot_n++; if (tb !== 0 || rb !== 0) $display("FAIL walk_stream: tx_bad=%0d req_bad=%0d want 0", tb, rb); else pass_n++;
        tot_n++; if (err_cnt !== 0 || done !== 1'b1 || last_rx !== 32'h02) $display("FAIL walk_end: err=%0d done=%0b last=%0h want 0 1 2", err_cnt, done, last_rx); else pass_n++;
    endtask

    task automatic test_endless_abort();
        int tb, rb, ti, ri; logic [31:0] l;
        run(0, 2'd0, 0, 0, 100, 100, -1, 0, 0, 20, tb, rb, ti, ri, l);
        tot_n++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL abort_state: busy=%0b done=%0b want 0 0", busy, done); else pass_n++;
        tot_n++; if (tx_cnt !== 20 || rx_cnt !== 32'(ri) || tb !== 0) $display("FAIL abort_hold: tx=%0d rx=%0d (want 20 %0d) tx_bad=%0d", tx_cnt, rx_cnt, ri, tb); else pass_n++;
        tot_n++; if (tx_req !== 1'b0 || rx_req !== 1'b0) $display("FAIL abort_req: tx=%0b rx=%0b want 0 0", tx_req, rx_req); else pass_n++;
        start_a = 1;
        @(negedge clk);
        start_a = 0;
        tot_n++; if (tx_cnt !== 0 || rx_cnt !== 0 || tx_data !== 0 || busy !== 1'b1) $display("FAIL restart: tx=%0d rx=%0d txd=%0h busy=%0b want 0 0 0 1", tx_cnt, rx_cnt, tx_data, busy); else pass_n++;
    endtask

    task automatic test_start_ignored();
        tx_gnt = 1;
        repeat (3) @(negedge clk);
        tx_gnt = 0; start_a = 1;
        @(negedge clk);
        start_a = 0;
        tot_n++; if (tx_cnt !== 3 || tx_data !== 3 || busy !== 1'b1) $display("FAIL start_in_run: tx=%0d txd=%0h busy=%0b want 3 3 1", tx_cnt, tx_data, busy); else pass_n++;
        abort = 1;
        @(negedge clk);
        abort = 0;
    endtask

    task automatic test_saturate();
        int tb, rb, ti, ri; logic [31:0] l;
        run(1, 2'd3, 32'hAA, 40, 100, 100, -1, 0, 1, -1, tb, rb, ti, ri, l);
        tot_n++; if (tb !== 0 || done !== 1'b1) $display("FAIL sat_stream: tx_bad=%0d done=%0b want 0 1", tb, done); else pass_n++;
        tot_n++; if (err_cnt !== 32'hF) $display("FAIL sat_cnt: got %0h want f", err_cnt); else pass_n++;
        tot_n++; if (err_idx !== 0 || err_got !== 32'h55) $display("FAIL sat_first: idx=%0d got=%0h want 0 55", err_idx, err_got); else pass_n++;
    endtask

    task automatic test_start_abort();
        start_b = 1; abort = 1;
        @(negedge clk);
        start_b = 0; abort = 0;
        tot_n++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL start_abort: busy=%0b done=%0b want 0 0", busy, done); else pass_n++;
        tot_n++; if (err_cnt !== 32'hF || rx_cnt !== 40) $display("FAIL start_abort_hold: err=%0h rx=%0d want f 40", err_cnt, rx_cnt); else pass_n++;
    endtask

    task automatic test_reset_midrun();
        sel = 0; len = 0; mode = 2'd0; start_a = 1;
        @(negedge clk);
        start_a = 0; tx_gnt = 1;
        repeat (4) @(negedge clk);
        tot_n++; if (busy !== 1'b1 || tx_cnt !== 4) $display("FAIL midrun_pre: busy=%0b tx=%0d want 1 4", busy, tx_cnt); else pass_n++;
        tx_gnt = 0; rst_n = 0;
        #1;
        tot_n++; if (busy !== 1'b0 || tx_cnt !== 0 || tx_data !== 0) $display("FAIL midrun_reset: busy=%0b tx=%0d txd=%0h want 0 0 0", busy, tx_cnt, tx_data); else pass_n++;
        @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        rst_n = 0; start_a = 0; start_b = 0; abort = 0; tx_gnt = 0; rx_gnt = 0;
        sel = 0; mode = 0; cval = 0; len = 0; rx_data = 0;
        test_reset();
        test_incr();
        test_rx_ignored();
        test_lfsr();
        test_error();
        test_walk();
        test_endless_abort();
        test_start_ignored();
        test_saturate();
        test_start_abort();
        test_reset_midrun();
        $display("%0d/%0d checks passed", pass_n, tot_n);
        $finish;
    end
endmodule
